// File: rtl/seq_mul_ctrl_if.sv
// Handshake and data bundle between a multiplier client and the sequential
// shift-and-add multiplier controller.
interface seq_mul_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one add/shift per clock through a
// WIDTH-bit adder, product presented with a one-cycle done strobe.
module seq_mul_ctrl #(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   seq_mul_ctrl_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mcand, mcand_next;
   logic [PW:0]      work, work_next;
   logic [CW-1:0]    count, count_next;
   logic [PW-1:0]    product, product_next;
   logic             busy, busy_next;
   logic             done, done_next;
   logic [WIDTH:0]   upper_sum;
   logic [PW:0]      added;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         work    <= '0;
         count   <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         mcand   <= mcand_next;
         work    <= work_next;
         count   <= count_next;
         product <= product_next;
         busy    <= busy_next;
         done    <= done_next;
      end
   end

   // Upper field is WIDTH+1 bits wide so the adder carry lands in the top bit.
   always_comb begin
      state_next   = state;
      mcand_next   = mcand;
      work_next    = work;
      count_next   = count;
      product_next = product;
      upper_sum    = work[PW:WIDTH] + {1'b0, mcand};
      added        = work;

      case (state)
         IDLE: begin
            if (bus.start) begin
               mcand_next = bus.a;
               work_next  = {1'b0, {WIDTH{1'b0}}, bus.b};
               count_next = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (work[0]) begin
               added = {upper_sum, work[WIDTH-1:0]};
            end
            work_next  = added >> 1;
            count_next = count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
               state_next   = DONE;
               product_next = work_next[PW-1:0];
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == BUSY);
      done_next = (state_next == DONE);
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.product = product;

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
Sequential shift-and-add multiplier controller for the team's multiplier datapaths. It accepts an operand pair on a start pulse and runs one add/shift iteration per clock through a WIDTH-bit partial-product adder. It then presents a 2*WIDTH-bit unsigned product with a one-cycle done strobe. It sits next to the combinational array multiplier as the area-cheap, multi-cycle alternative, and has the same unsigned semantics.

Parameters:
WIDTH, 4, operand width in bits (valid range 2..16); product width is 2*WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin a multiplication; sampled only in IDLE
a  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge only
b  input  WIDTH  multiplier, unsigned; sampled on the accepting edge only
busy  output  1  high while an operation is in progress (state BUSY)
done  output  1  one-cycle strobe: product valid and newly updated
product  output  2*WIDTH  result of the last completed operation; held until the next completion

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, product=0, internal registers cleared. Reset overrides start.
- Reset mid-operation aborts the operation. No done is issued and product reads 0.
- States: IDLE, BUSY, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE: if start=1 at an edge, the operation is accepted at that edge:
  - Latch a into mcand (WIDTH bits).
  - Load the work register P (2*WIDTH+1 bits) with {0, WIDTH'b0, b}.
  - Set count=0. Next state is BUSY and busy=1.
  - If start=0, remain in IDLE.
- BUSY, one iteration per edge:
  - If P[0]=1, add mcand to the upper field P[2*WIDTH:WIDTH] as a (WIDTH+1)-bit addition. The carry is kept in bit 2*WIDTH and never lost.
  - Then logically shift P right by 1 with a zero fill. Increment count.
  - When the iteration with count=WIDTH-1 completes, go to DONE. On that same edge, load product with P[2*WIDTH-1:0] (the post-shift value), set done=1 and busy=0.
- DONE: lasts exactly one cycle. On the next edge, go to IDLE with done=0. product is held.
- Latency: if start is accepted at edge k, busy is high during the cycles after edges k..k+WIDTH-1. done is high during the single cycle after edge k+WIDTH. The earliest next accept is edge k+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- start while BUSY or DONE is ignored; operands are not re-sampled. start held high continuously restarts at the first IDLE edge.
- Changes on a or b after acceptance have no effect on the running operation.
- product changes only on the completing edge or on reset. Between completions it holds the last result, including while a new operation is BUSY.
- Arithmetic is unsigned; the result always fits 2*WIDTH bits with no overflow (max (2^W-1)^2).
- Zero operands still take the full WIDTH iterations; there is no early termination.

Test Plan:
- Reset then idle, WIDTH=4: rst=1 for 2 cycles, start=0 -> busy=0, done=0, product=0x00 and stable for 10 cycles.
- Basic products, WIDTH=4, each with start high for one cycle then waiting for done:
  - a=0,b=0 -> product=0x00.
  - a=2,b=3 -> product=0x06.
  - a=1,b=1 -> product=0x01.
  - a=3,b=1 -> product=0x03.
  - For each: done is high exactly one cycle, 5 cycles after the accepting edge, and busy is high for exactly 4 cycles.
- Carry/max, WIDTH=4: a=15,b=15 -> product=0xE1 (225). a=15,b=1 -> 0x0F. a=1,b=15 -> 0x0F. a=8,b=8 -> 0x40.
- Ignored start: accept a=5,b=3, then pulse start with a=7,b=7 in BUSY and again in the DONE cycle -> exactly one done, product=0x0F. The next start in IDLE with a=7,b=7 -> product=0x31.
- Reset mid-operation: accept a=9,b=9, assert rst on the 2nd BUSY cycle -> busy=0, done never pulses, product=0. A subsequent a=9,b=9 -> 0x51.
- Back-to-back and hold: start held high for 20 cycles with a=6,b=5 -> done pulses every 6 cycles, product=0x1E each time. Product holds its value between pulses.
